// File: rtl/rx_frame_ctrl.sv
// rtl/rx_frame_ctrl.sv - framed byte receiver: CRC/count header capture, payload RAM writes, CTS flow control
module rx_frame_ctrl #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 150000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rts_i,
  input  logic              byte_valid_i,
  input  logic [7:0]        byte_i,
  input  logic              parity_err_i,
  output logic              cts_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [7:0]        mem_data_o,
  output logic [31:0]       crc_value_o,
  output logic [15:0]       pkt_count_o,
  output logic              crc_start_o,
  output logic              done_o,
  output logic [1:0]        error_o
);

  localparam int               TMO_W    = $clog2(TIMEOUT + 1);
  localparam logic [16:0]      MAX_CNT  = 17'(1) << ADDR_W;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_CRC,
    S_HDR_CNT,
    S_PAYLOAD,
    S_FINISH,
    S_ERR
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        idx_q, idx_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [16:0]       remain_q, remain_d;
  logic [31:0]       crc_q, crc_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]        mem_data_q, mem_data_d;
  logic              crc_start_q, crc_start_d;
  logic              done_q, done_d;
  logic [1:0]        err_q, err_d;
  logic [15:0]       new_cnt;
  logic              go_finish;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      tmo_q       <= '0;
      wr_addr_q   <= '0;
      remain_q    <= '0;
      crc_q       <= '0;
      cnt_q       <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_data_q  <= '0;
      crc_start_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      wr_addr_q   <= wr_addr_d;
      remain_q    <= remain_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_data_q  <= mem_data_d;
      crc_start_q <= crc_start_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    wr_addr_d   = wr_addr_q;
    remain_d    = remain_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_data_d  = mem_data_q;
    crc_start_d = 1'b0;
    done_d      = done_q;
    err_d       = err_q;
    new_cnt     = {cnt_q[7:0], byte_i};
    go_finish   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (rts_i) begin
          state_d = S_HDR_CRC;
          idx_d   = '0;
          tmo_d   = '0;
          done_d  = 1'b0;
          err_d   = 2'd0;
        end
      end
      S_FINISH, S_ERR: begin
        if (!rts_i) state_d = S_IDLE;
      end
      default: begin
        // Active frame: an RTS drop outranks any byte arriving in the same cycle.
        if (!rts_i) begin
          state_d = S_IDLE;
          done_d  = 1'b0;
          err_d   = 2'd0;
        end else if (byte_valid_i && parity_err_i) begin
          err_d   = 2'd1;
          state_d = S_ERR;
        end else if (byte_valid_i) begin
          tmo_d = '0;
          case (state_q)
            S_HDR_CRC: begin
              crc_d = {crc_q[23:0], byte_i};
              idx_d = idx_q + 3'd1;
              if (idx_q == 3'd3) begin
                idx_d   = '0;
                state_d = S_HDR_CNT;
              end
            end
            S_HDR_CNT: begin
              cnt_d = new_cnt;
              idx_d = idx_q + 3'd1;
              if (idx_q == 3'd1) begin
                idx_d = '0;
                if (new_cnt == 16'd0) begin
                  go_finish = 1'b1;
                end else if ({1'b0, new_cnt} > MAX_CNT) begin
                  err_d   = 2'd3;
                  state_d = S_ERR;
                end else begin
                  state_d   = S_PAYLOAD;
                  wr_addr_d = '0;
                  remain_d  = {1'b0, new_cnt};
                end
              end
            end
            default: begin
              mem_we_d   = 1'b1;
              mem_addr_d = wr_addr_q;
              mem_data_d = byte_i;
              wr_addr_d  = wr_addr_q + ADDR_W'(1);
              remain_d   = remain_q - 17'd1;
              if (remain_q == 17'd1) go_finish = 1'b1;
            end
          endcase
        end else if (tmo_q == TMO_LAST) begin
          err_d   = 2'd2;
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
    endcase

    if (go_finish) begin
      state_d     = S_FINISH;
      done_d      = 1'b1;
      crc_start_d = 1'b1;
    end
  end

  assign cts_o       = (state_q == S_HDR_CRC) || (state_q == S_HDR_CNT) || (state_q == S_PAYLOAD);
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_data_o  = mem_data_q;
  assign crc_value_o = crc_q;
  assign pkt_count_o = cnt_q;
  assign crc_start_o = crc_start_q;
  assign done_o      = done_q;
  assign error_o     = err_q;

endmodule

// File: tb/tb_rx_frame_ctrl.sv
// tb/tb_rx_frame_ctrl.sv - self-checking bench for rx_frame_ctrl (vector table, corner sequences, random frames vs model)
module tb_rx_frame_ctrl;
  localparam int AW   = 4;
  localparam int TMO  = 100;
  localparam int MAXN = 16;

  logic        clk = 1'b0;
  logic        rst, rts, bv, par;
  logic [7:0]  bin;
  logic        cts, mem_we, crc_start, done;
  logic [AW-1:0] mem_addr;
  logic [7:0]  mem_data;
  logic [31:0] crc_value;
  logic [15:0] pkt_count;
  logic [1:0]  err;

  rx_frame_ctrl #(.ADDR_W(AW), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst), .rts_i(rts), .byte_valid_i(bv), .byte_i(bin),
    .parity_err_i(par), .cts_o(cts), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_data_o(mem_data), .crc_value_o(crc_value), .pkt_count_o(pkt_count),
    .crc_start_o(crc_start), .done_o(done), .error_o(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int we_seen = 0;

  // Reference: frame phase (0 idle, 1 receiving, 2 finished, 3 failed) and byte position in frame
  int          ph = 0, pos = 0, quiet = 0;
  logic [31:0] m_crc = '0;
  logic [15:0] m_cnt = '0;
  logic        m_we = 1'b0, m_start = 1'b0, m_done = 1'b0;
  logic [3:0]  m_addr = '0;
  logic [7:0]  m_data = '0;
  logic [1:0]  m_err = '0;

  typedef struct {
    logic rts, bv; logic [7:0] b;
    logic cts, we; logic [3:0] addr; logic [7:0] data; logic start, done; logic [1:0] err;
  } vec_t;
  vec_t tbl[13];

  function automatic vec_t mk(int rq, int v, int b, int c, int w, int a, int d, int st, int dn, int e);
    vec_t t;
    t.rts = 1'(rq); t.bv = 1'(v); t.b = 8'(b); t.cts = 1'(c); t.we = 1'(w);
    t.addr = 4'(a); t.data = 8'(d); t.start = 1'(st); t.done = 1'(dn); t.err = 2'(e);
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_finish();
    m_done = 1'b1; m_start = 1'b1; ph = 2;
  endtask

  task automatic model_edge(input logic r, input logic rq, input logic v, input logic [7:0] b, input logic p);
    m_we = 1'b0; m_start = 1'b0;
    if (r) begin
      ph = 0; pos = 0; quiet = 0; m_crc = '0; m_cnt = '0; m_addr = '0; m_data = '0;
      m_done = 1'b0; m_err = '0;
    end else if (ph == 0) begin
      if (rq) begin ph = 1; pos = 0; quiet = 0; m_done = 1'b0; m_err = '0; end
    end else if (ph == 1) begin
      if (!rq) begin
        ph = 0; m_done = 1'b0; m_err = '0;
      end else if (v && p) begin
        m_err = 2'd1; ph = 3;
      end else if (v) begin
        quiet = 0;
        if (pos < 4) m_crc = {m_crc[23:0], b};
        else if (pos < 6) m_cnt = {m_cnt[7:0], b};
        else begin m_we = 1'b1; m_addr = 4'(pos - 6); m_data = b; end
        pos++;
        if (pos == 6 && m_cnt == 0) model_finish();
        else if (pos == 6 && int'(m_cnt) > MAXN) begin m_err = 2'd3; ph = 3; end
        else if (pos > 6 && pos - 6 == int'(m_cnt)) model_finish();
      end else begin
        quiet++;
        if (quiet == TMO) begin m_err = 2'd2; ph = 3; end
      end
    end else begin
      if (!rq) ph = 0;
    end
  endtask

  task automatic cmp_model();
    chk("m_cts", 32'(cts), 32'(ph == 1));
    chk("m_we", 32'(mem_we), 32'(m_we));
    chk("m_addr", 32'(mem_addr), 32'(m_addr));
    chk("m_data", 32'(mem_data), 32'(m_data));
    chk("m_crc", crc_value, m_crc);
    chk("m_cnt", 32'(pkt_count), 32'(m_cnt));
    chk("m_start", 32'(crc_start), 32'(m_start));
    chk("m_done", 32'(done), 32'(m_done));
    chk("m_err", 32'(err), 32'(m_err));
  endtask

  task automatic step(input logic r, input logic rq, input logic v, input logic [7:0] b, input logic p);
    rst = r; rts = rq; bv = v; bin = b; par = p;
    @(posedge clk);
    model_edge(r, rq, v, b, p);
    @(negedge clk);
    cmp_model();
    if (mem_we) we_seen++;
  endtask

  task automatic idle(input logic rq);
    step(1'b0, rq, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b0, 1'b1, 1'b1, b, 1'b0);
  endtask

  task automatic send_hdr(input logic [15:0] n);
    send(8'hDE); send(8'hAD); send(8'hBE); send(8'hEF);
    send(n[15:8]); send(n[7:0]);
  endtask

  initial begin
    logic [7:0] fb[$];
    int n, gap;

    tbl[0]  = mk(1, 0, 'h00, 1, 0, 0, 'h00, 0, 0, 0);
    tbl[1]  = mk(1, 1, 'hDE, 1, 0, 0, 'h00, 0, 0, 0);
    tbl[2]  = mk(1, 1, 'hAD, 1, 0, 0, 'h00, 0, 0, 0);
    tbl[3]  = mk(1, 1, 'hBE, 1, 0, 0, 'h00, 0, 0, 0);
    tbl[4]  = mk(1, 1, 'hEF, 1, 0, 0, 'h00, 0, 0, 0);
    tbl[5]  = mk(1, 1, 'h00, 1, 0, 0, 'h00, 0, 0, 0);
    tbl[6]  = mk(1, 1, 'h03, 1, 0, 0, 'h00, 0, 0, 0);
    tbl[7]  = mk(1, 1, 'h11, 1, 1, 0, 'h11, 0, 0, 0);
    tbl[8]  = mk(1, 1, 'h22, 1, 1, 1, 'h22, 0, 0, 0);
    tbl[9]  = mk(1, 1, 'h33, 0, 1, 2, 'h33, 1, 1, 0);
    tbl[10] = mk(1, 0, 'h00, 0, 0, 2, 'h33, 0, 1, 0);
    tbl[11] = mk(0, 0, 'h00, 0, 0, 2, 'h33, 0, 1, 0);
    tbl[12] = mk(0, 0, 'h00, 0, 0, 2, 'h33, 0, 1, 0);

    step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'hFF, 1'b0);
    chk("rst_cts", 32'(cts), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_crc", crc_value, 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    step(1'b0, 1'b0, 1'b1, 8'h5A, 1'b0);
    chk("idle_ignores_byte", crc_value, 0);

    for (int i = 0; i < 13; i++) begin
      step(1'b0, tbl[i].rts, tbl[i].bv, tbl[i].b, 1'b0);
      chk($sformatf("tbl%0d_cts", i), 32'(cts), 32'(tbl[i].cts));
      chk($sformatf("tbl%0d_we", i), 32'(mem_we), 32'(tbl[i].we));
      chk($sformatf("tbl%0d_addr", i), 32'(mem_addr), 32'(tbl[i].addr));
      chk($sformatf("tbl%0d_data", i), 32'(mem_data), 32'(tbl[i].data));
      chk($sformatf("tbl%0d_start", i), 32'(crc_start), 32'(tbl[i].start));
      chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].done));
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].err));
    end
    chk("tbl_crc_value", crc_value, 32'hDEADBEEF);
    chk("tbl_pkt_count", 32'(pkt_count), 3);

    we_seen = 0;
    idle(1'b1);
    chk("zero_done_cleared", 32'(done), 0);
    send_hdr(16'h0000);
    chk("zero_start", 32'(crc_start), 1);
    chk("zero_done", 32'(done), 1);
    chk("zero_cts", 32'(cts), 0);
    idle(1'b1);
    chk("zero_start_once", 32'(crc_start), 0);
    idle(1'b0);
    chk("zero_no_we", 32'(we_seen), 0);

    we_seen = 0;
    idle(1'b1);
    send_hdr(16'h0005);
    send(8'hA1);
    step(1'b0, 1'b1, 1'b1, 8'hA2, 1'b1);
    chk("par_err", 32'(err), 1);
    chk("par_cts", 32'(cts), 0);
    idle(1'b1); idle(1'b1);
    idle(1'b0);
    chk("par_err_held_idle", 32'(err), 1);
    idle(1'b0);
    chk("par_one_write", 32'(we_seen), 1);
    chk("par_last_addr", 32'(mem_addr), 0);
    idle(1'b1);
    chk("par_err_cleared", 32'(err), 0);
    chk("par_restart_cts", 32'(cts), 1);
    idle(1'b0);

    idle(1'b1);
    send_hdr(16'h0011);
    chk("ovf_err", 32'(err), 3);
    chk("ovf_cts", 32'(cts), 0);
    idle(1'b0);

    we_seen = 0;
    idle(1'b1);
    send_hdr(16'h0010);
    for (int i = 0; i < 16; i++) begin
      send(8'(i * 7 + 1));
      chk($sformatf("bnd_addr%0d", i), 32'(mem_addr), 32'(i));
    end
    chk("bnd_done", 32'(done), 1);
    chk("bnd_err", 32'(err), 0);
    idle(1'b0);
    chk("bnd_writes", 32'(we_seen), 16);

    idle(1'b1);
    send(8'h01); send(8'h02);
    repeat (99) idle(1'b1);
    chk("tmo_99_no_err", 32'(err), 0);
    idle(1'b1);
    chk("tmo_100_err", 32'(err), 2);
    chk("tmo_cts", 32'(cts), 0);
    idle(1'b0);

    idle(1'b1);
    send(8'h01); send(8'h02);
    repeat (99) idle(1'b1);
    send(8'h55);
    chk("tmo_byte_wins_err", 32'(err), 0);
    chk("tmo_byte_wins_cts", 32'(cts), 1);
    repeat (99) idle(1'b1);
    chk("tmo_restart_99", 32'(err), 0);
    idle(1'b1);
    chk("tmo_restart_100", 32'(err), 2);
    idle(1'b0);

    idle(1'b1);
    send_hdr(16'h0004);
    send(8'h71); send(8'h72);
    step(1'b0, 1'b0, 1'b1, 8'h99, 1'b0);
    chk("abort_cts", 32'(cts), 0);
    chk("abort_err", 32'(err), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_start", 32'(crc_start), 0);
    chk("abort_no_we", 32'(mem_we), 0);
    idle(1'b0);

    idle(1'b1);
    send(8'h12); send(8'h34);
    step(1'b1, 1'b1, 1'b1, 8'h56, 1'b0);
    chk("rst_mid_cts", 32'(cts), 0);
    chk("rst_mid_crc", crc_value, 0);
    chk("rst_mid_cnt", 32'(pkt_count), 0);
    chk("rst_mid_addr", 32'(mem_addr), 0);
    idle(1'b0);

    for (int f = 0; f < 60; f++) begin
      if ($urandom_range(0, 19) == 0) step(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      repeat ($urandom_range(1, 3)) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
      idle(1'b1);
      n = $urandom_range(0, 18);
      fb.delete();
      repeat (4) fb.push_back(8'($urandom));
      fb.push_back(8'(n >> 8));
      fb.push_back(8'(n));
      repeat (n) fb.push_back(8'($urandom));
      for (int k = 0; k < fb.size(); k++) begin
        if (ph != 1) break;
        gap = ($urandom_range(0, 39) == 0) ? $urandom_range(95, 105) : $urandom_range(0, 2);
        for (int g = 0; g < gap && ph == 1; g++)
          step(1'b0, 1'($urandom_range(0, 149) != 0), 1'b0, 8'h00, 1'b0);
        if (ph != 1) break;
        step(1'b0, 1'b1, 1'b1, fb[k], 1'($urandom_range(0, 59) == 0));
      end
      repeat ($urandom_range(1, 3)) idle(1'b1);
      idle(1'b0); idle(1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
